// File: rtl/cpu_defs.sv
// Shared definitions for the 20-bit processor control path: opcodes, FSM states,
// ALU operation codes, instruction field positions and the reset instruction word.
package cpu_defs;

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpAdd  = 4'd1;
  localparam logic [3:0] OpAddi = 4'd2;
  localparam logic [3:0] OpAndi = 4'd3;
  localparam logic [3:0] OpNand = 4'd4;
  localparam logic [3:0] OpNor  = 4'd5;
  localparam logic [3:0] OpLd   = 4'd6;
  localparam logic [3:0] OpSt   = 4'd7;
  localparam logic [3:0] OpJump = 4'd8;
  localparam logic [3:0] OpBeq  = 4'd9;
  localparam logic [3:0] OpBlt  = 4'd10;
  localparam logic [3:0] OpBgt  = 4'd11;
  localparam logic [3:0] OpHlt  = 4'd14;
  localparam logic [3:0] OpNop  = 4'd15;

  localparam logic [2:0] AluAnd  = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluNand = 3'd2;
  localparam logic [2:0] AluNor  = 3'd3;
  localparam logic [2:0] AluSub  = 3'd4;

  localparam int unsigned OpcMsb  = 19;
  localparam int unsigned OpcLsb  = 16;
  localparam int unsigned RegAMsb = 15;
  localparam int unsigned RegALsb = 12;
  localparam int unsigned RegBMsb = 11;
  localparam int unsigned RegBLsb = 8;
  localparam int unsigned RegCMsb = 7;
  localparam int unsigned RegCLsb = 4;
  localparam int unsigned Imm8Msb = 7;
  localparam int unsigned Off12Msb = 11;

  localparam logic [19:0] NopWord = 20'hF0000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-unit boundary: instruction fetch, datapath selects, flags and the
// data-RAM request handshake. master = control unit, slave = datapath side.
interface cpu_control_fsm_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 20
);
  logic [DATA_W-1:0] imem_rdata;
  logic              mem_ack;
  logic              zero_flag;
  logic              neg_flag;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              is_arithmetic;
  logic              is_store;
  logic              is_branch;
  logic [2:0]        alu_op;
  logic              alu_src_imm;
  logic [DATA_W-1:0] imm;
  logic              rf_we;
  logic              mem_req;
  logic              mem_we;
  logic              halted;

  modport master (
    input  imem_rdata, mem_ack, zero_flag, neg_flag,
    output pc, ir, is_arithmetic, is_store, is_branch, alu_op, alu_src_imm, imm,
           rf_we, mem_req, mem_we, halted
  );

  modport slave (
    output imem_rdata, mem_ack, zero_flag, neg_flag,
    input  pc, ir, is_arithmetic, is_store, is_branch, alu_op, alu_src_imm, imm,
           rf_we, mem_req, mem_we, halted
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: datapath selects, ALU operation and the
// instruction-class bits the sequencer branches on.
module instr_decoder
  import cpu_defs::*;
(
  input  logic [3:0] opcode,
  output logic       is_arithmetic,
  output logic       is_store,
  output logic       is_branch,
  output logic       alu_src_imm,
  output logic [2:0] alu_op,
  output logic       is_mem,
  output logic       is_jump,
  output logic       is_halt
);

  always_comb begin
    is_arithmetic = 1'b0;
    is_store      = 1'b0;
    is_branch     = 1'b0;
    alu_src_imm   = 1'b0;
    alu_op        = AluAnd;
    is_mem        = 1'b0;
    is_jump       = 1'b0;
    is_halt       = 1'b0;
    case (opcode)
      OpAnd:  begin is_arithmetic = 1'b1; alu_op = AluAnd; end
      OpAdd:  begin is_arithmetic = 1'b1; alu_op = AluAdd; end
      OpAddi: begin is_arithmetic = 1'b1; alu_op = AluAdd; alu_src_imm = 1'b1; end
      OpAndi: begin is_arithmetic = 1'b1; alu_op = AluAnd; alu_src_imm = 1'b1; end
      OpNand: begin is_arithmetic = 1'b1; alu_op = AluNand; end
      OpNor:  begin is_arithmetic = 1'b1; alu_op = AluNor; end
      OpLd:   begin is_mem = 1'b1; alu_op = AluAdd; alu_src_imm = 1'b1; end
      OpSt:   begin is_mem = 1'b1; is_store = 1'b1; alu_op = AluAdd; alu_src_imm = 1'b1; end
      OpJump: is_jump = 1'b1;
      OpBeq, OpBlt, OpBgt: begin is_branch = 1'b1; alu_op = AluSub; end
      OpHlt:  is_halt = 1'b1;
      default: ;  // NOP and reserved 12-13
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: latches and decodes instructions, sequences
// FETCH/DECODE/EXEC/MEM/WB, owns the PC and the data-RAM request handshake.
module cpu_control_fsm
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 20
) (
  input logic               clk,
  input logic               rst,
  cpu_control_fsm_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic              rf_we_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              halted_q;

  logic       dec_arith;
  logic       dec_store;
  logic       dec_branch;
  logic       dec_src_imm;
  logic [2:0] dec_alu_op;
  logic       dec_mem;
  logic       dec_jump;
  logic       dec_halt;

  instr_decoder u_decoder (
    .opcode        (ir_q[OpcMsb:OpcLsb]),
    .is_arithmetic (dec_arith),
    .is_store      (dec_store),
    .is_branch     (dec_branch),
    .alu_src_imm   (dec_src_imm),
    .alu_op        (dec_alu_op),
    .is_mem        (dec_mem),
    .is_jump       (dec_jump),
    .is_halt       (dec_halt)
  );

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] off_ext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_jump;
  logic [ADDR_W-1:0] pc_branch;
  logic              br_taken;

  // Offsets are sign-extended to the word width, then truncated to the PC width.
  assign imm_ext   = {{(DATA_W-8){ir_q[Imm8Msb]}}, ir_q[Imm8Msb:0]};
  assign off_ext   = {{(DATA_W-12){ir_q[Off12Msb]}}, ir_q[Off12Msb:0]};
  assign pc_inc    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign pc_jump   = pc_inc + off_ext[ADDR_W-1:0];
  assign pc_branch = pc_inc + imm_ext[ADDR_W-1:0];

  always_comb begin
    br_taken = 1'b0;
    case (ir_q[OpcMsb:OpcLsb])
      OpBeq:   br_taken = bus.zero_flag;
      OpBlt:   br_taken = bus.neg_flag;
      OpBgt:   br_taken = !bus.neg_flag && !bus.zero_flag;
      default: br_taken = 1'b0;
    endcase
  end

  // Strobes are registered on entry to their state, so they are pure functions of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      ir_q      <= NopWord;
      rf_we_q   <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q    <= bus.imem_rdata;
          state_q <= StDecode;
        end
        StDecode: begin
          if (dec_halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (dec_arith) begin
            state_q <= StWb;
            rf_we_q <= 1'b1;
          end else if (dec_mem) begin
            state_q   <= StMem;
            mem_req_q <= 1'b1;
            mem_we_q  <= dec_store;
          end else if (dec_jump) begin
            pc_q    <= pc_jump;
            state_q <= StFetch;
          end else if (dec_branch) begin
            pc_q    <= br_taken ? pc_branch : pc_inc;
            state_q <= StFetch;
          end else begin
            pc_q    <= pc_inc;
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (dec_store) begin
              pc_q    <= pc_inc;
              state_q <= StFetch;
            end else begin
              rf_we_q <= 1'b1;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          rf_we_q <= 1'b0;
          pc_q    <= pc_inc;
          state_q <= StFetch;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ir            = ir_q;
  assign bus.is_arithmetic = dec_arith;
  assign bus.is_store      = dec_store;
  assign bus.is_branch     = dec_branch;
  assign bus.alu_op        = dec_alu_op;
  assign bus.alu_src_imm   = dec_src_imm;
  assign bus.imm           = imm_ext;
  assign bus.rf_we         = rf_we_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.halted        = halted_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: runs a hand-assembled instruction sequence
// and checks cycle counts, strobes, decode outputs and PC updates.
module tb_cpu_control_fsm;

  logic clk;
  logic rst;

  cpu_control_fsm_if #(.ADDR_W(10), .DATA_W(20)) bus ();

  cpu_control_fsm #(.ADDR_W(10), .DATA_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] model_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // dec = {is_arithmetic, is_store, is_branch, alu_src_imm, alu_op[2:0]}
  task automatic run_instr(input string tag, input logic [19:0] word, input int n,
                           input int ack_cycle, input int rf_cycle, input int req_exp,
                           input logic exp_we, input logic [6:0] exp_dec,
                           input logic [19:0] exp_imm, input logic [9:0] exp_pc);
    int rf_cnt = 0;
    int rf_at = 0;
    int req_cnt = 0;
    bus.imem_rdata = word;
    for (int k = 1; k <= n; k++) begin
      bus.mem_ack = (k == ack_cycle);
      if (bus.rf_we) begin
        rf_cnt++;
        rf_at = k;
      end
      if (bus.mem_req) begin
        req_cnt++;
        check_eq({tag, " mem_we"}, bus.mem_we, exp_we);
      end
      if (k == 3) begin
        check_eq({tag, " ir"}, bus.ir, word);
        check_eq({tag, " dec"}, {bus.is_arithmetic, bus.is_store, bus.is_branch,
                                 bus.alu_src_imm, bus.alu_op}, exp_dec);
        check_eq({tag, " imm"}, bus.imm, exp_imm);
      end
      if (k < n) check_eq({tag, " pc held"}, bus.pc, model_pc);
      @(posedge clk);
      #1;
    end
    bus.mem_ack = 1'b0;
    check_eq({tag, " pc"}, bus.pc, exp_pc);
    check_eq({tag, " rf_we count"}, rf_cnt, (rf_cycle != 0) ? 1 : 0);
    check_eq({tag, " rf_we cycle"}, rf_at, rf_cycle);
    check_eq({tag, " mem_req cycles"}, req_cnt, req_exp);
    check_eq({tag, " mem_req after"}, bus.mem_req, 1'b0);
    model_pc = exp_pc;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_rdata = 20'hF0000;
    bus.mem_ack = 1'b0;
    bus.zero_flag = 1'b0;
    bus.neg_flag = 1'b0;
    model_pc = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset pc", bus.pc, 10'd0);
    check_eq("reset ir", bus.ir, 20'hF0000);
    check_eq("reset strobes", {bus.rf_we, bus.mem_req, bus.mem_we, bus.halted}, 4'b0000);
    check_eq("reset dec", {bus.is_arithmetic, bus.is_store, bus.is_branch,
                           bus.alu_src_imm, bus.alu_op}, 7'd0);
    rst = 1'b0;

    run_instr("ADD",  20'h11230, 4, 0, 4, 0, 1'b0, 7'b1000_001, 20'h00030, 10'd1);
    run_instr("LD",   20'h64005, 7, 6, 7, 3, 1'b0, 7'b0001_001, 20'h00005, 10'd2);
    run_instr("JMP5", 20'h80002, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00002, 10'd5);
    run_instr("ST",   20'h720FF, 4, 4, 0, 1, 1'b1, 7'b0101_001, 20'hFFFFF, 10'd6);
    run_instr("JMP10", 20'h80003, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00003, 10'd10);
    bus.zero_flag = 1'b1;
    run_instr("BEQ taken", 20'h900FC, 3, 0, 0, 0, 1'b0, 7'b0010_100, 20'hFFFFC, 10'd7);
    bus.zero_flag = 1'b0;
    run_instr("JMP10b", 20'h80002, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00002, 10'd10);
    run_instr("BEQ not", 20'h900FC, 3, 0, 0, 0, 1'b0, 7'b0010_100, 20'hFFFFC, 10'd11);
    run_instr("BGT taken", 20'hB0004, 3, 0, 0, 0, 1'b0, 7'b0010_100, 20'h00004, 10'd16);
    bus.neg_flag = 1'b1;
    run_instr("BLT taken", 20'hA0002, 3, 0, 0, 0, 1'b0, 7'b0010_100, 20'h00002, 10'd19);
    bus.neg_flag = 1'b0;
    run_instr("JMP1023", 20'h803EB, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'hFFFEB, 10'd1023);
    run_instr("JMP wrap", 20'h80001, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00001, 10'd1);
    run_instr("RSVD", 20'hC0000, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00000, 10'd2);

    // Reset while LD is waiting in MEM: request must drop without a clock edge.
    bus.imem_rdata = 20'h64005;
    bus.mem_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst-mem req before", bus.mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst-mem req", bus.mem_req, 1'b0);
    check_eq("rst-mem pc", bus.pc, 10'd0);
    check_eq("rst-mem ir", bus.ir, 20'hF0000);
    check_eq("rst-mem rf_we", bus.rf_we, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_pc = 10'd0;
    run_instr("NOP after rst", 20'hF0000, 3, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00000, 10'd1);

    run_instr("HLT", 20'hE0000, 2, 0, 0, 0, 1'b0, 7'b0000_000, 20'h00000, 10'd1);
    bus.imem_rdata = 20'h11230;
    for (int i = 0; i < 20; i++) begin
      check_eq("halt flag", bus.halted, 1'b1);
      check_eq("halt pc", bus.pc, 10'd1);
      check_eq("halt strobes", {bus.rf_we, bus.mem_req, bus.mem_we}, 3'b000);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
